// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between the EXE/MEM pipeline register, the data
// memory and mem_access_ctrl. slave = controller view, master = surroundings.
interface mem_access_ctrl_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        freeze;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;

  modport slave (
    input  mem_r_en, mem_w_en, addr_in, wdata_in, dm_rdata,
    output dm_read, dm_write, dm_addr, dm_wdata, freeze, rdata, rdata_valid, fault
  );

  modport master (
    output mem_r_en, mem_w_en, addr_in, wdata_in, dm_rdata,
    input  dm_read, dm_write, dm_addr, dm_wdata, freeze, rdata, rdata_valid, fault
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory access controller with pipeline freeze.
// Optional address checking enabled by defining MEM_CTRL_ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_access_ctrl: WAIT_CYCLES must be 1..15");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("mem_access_ctrl: BASE_ADDR must be word aligned");
  end

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        is_load;
  logic        req_one;
  logic        req_both;
  logic        addr_bad;
  logic        accept;

  assign req_one  = bus.mem_r_en ^ bus.mem_w_en;
  assign req_both = bus.mem_r_en & bus.mem_w_en;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign addr_bad = (bus.addr_in[1:0] != 2'b00) || (bus.addr_in < BASE_ADDR);
`else
  assign addr_bad = 1'b0;
`endif

  // A cycle with reset asserted never accepts or faults, so freeze stays low.
  assign accept = rst && (state == IDLE) && req_one && !addr_bad;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.freeze      = 1'b0;
    bus.dm_read     = 1'b0;
    bus.dm_write    = 1'b0;
    bus.rdata_valid = 1'b0;
    bus.fault       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          bus.freeze = 1'b1;
          state_nxt  = ACCESS;
        end else if (rst && (req_both || (req_one && addr_bad))) begin
          bus.fault = 1'b1;
        end
      end
      ACCESS: begin
        bus.freeze   = 1'b1;
        bus.dm_read  = is_load;
        bus.dm_write = !is_load && (cnt == 4'd0);
        if (cnt == 4'd0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.rdata_valid = is_load;
        state_nxt       = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      is_load      <= 1'b0;
      bus.dm_addr  <= '0;
      bus.dm_wdata <= '0;
      bus.rdata    <= '0;
    end else begin
      if (accept) begin
        cnt          <= CNT_INIT;
        is_load      <= bus.mem_r_en;
        bus.dm_addr  <= bus.addr_in;
        bus.dm_wdata <= bus.wdata_in;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ACCESS && is_load && cnt == 4'd0) begin
        bus.rdata <= bus.dm_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected load data is queued when a
// load is issued and compared when rdata_valid pulses.
module tb_mem_access_ctrl;

  localparam int unsigned WC = 3;

  logic clk;
  logic rst;
  mem_access_ctrl_if bus();

  mem_access_ctrl #(.WAIT_CYCLES(WC), .BASE_ADDR(32'h0000_0400)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model written only by DUT strobes; ref_mem is the bench's own view
  logic [31:0] mem     [16] = '{default: 32'h0};
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  assign bus.dm_rdata = mem[bus.dm_addr[5:2]];
  always @(posedge clk) begin
    if (bus.dm_write) mem[bus.dm_addr[5:2]] <= bus.dm_wdata;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] sb_q[$];
  int freeze_cnt, wr_cnt, rd_cnt, fault_cnt, valid_cnt, wr_at;
  logic [31:0] wr_addr, wr_data;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] last_addr  = 32'h0;

  task automatic clr_mon();
    freeze_cnt = 0; wr_cnt = 0; rd_cnt = 0; fault_cnt = 0; valid_cnt = 0; wr_at = 0;
    wr_addr = '0; wr_data = '0;
  endtask

  always @(negedge clk) begin
    if (bus.freeze) freeze_cnt++;
    if (bus.dm_read) rd_cnt++;
    if (bus.fault) fault_cnt++;
    if (bus.dm_write) begin
      wr_cnt++;
      wr_at   = freeze_cnt;
      wr_addr = bus.dm_addr;
      wr_data = bus.dm_wdata;
    end
    if (bus.rdata_valid) begin
      valid_cnt++;
      if (sb_q.size() == 0) check("sb_unexpected_valid", 32'd1, 32'd0);
      else check("sb_rdata", bus.rdata, sb_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit seen);
    bit done = 0;
    seen = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.freeze) seen = 1;
      else done = 1;
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  // one request held until the DONE cycle (or the fault cycle), then dropped
  task automatic run_req(input string tag, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input bit ok);
    bit seen;
    clr_mon();
    if (ok && r) begin
      sb_q.push_back(ref_mem[a[5:2]]);
      last_rdata = ref_mem[a[5:2]];
    end
    if (ok && w) ref_mem[a[5:2]] = d;
    if (ok) last_addr = a;
    bus.mem_r_en = r; bus.mem_w_en = w; bus.addr_in = a; bus.wdata_in = d;
    wait_done(seen);
    check({tag, "_valid_in_done"}, 32'(bus.rdata_valid), 32'(ok && r));
    @(posedge clk); #1;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    check({tag, "_freeze_cycles"}, freeze_cnt, ok ? WC + 1 : 0);
    check({tag, "_writes"},        wr_cnt,     32'(ok && w));
    check({tag, "_read_cycles"},   rd_cnt,     (ok && r) ? WC : 0);
    check({tag, "_faults"},        fault_cnt,  32'(!ok));
    check({tag, "_valids"},        valid_cnt,  32'(ok && r));
    check({tag, "_dm_addr"},       bus.dm_addr, last_addr);
    check({tag, "_rdata_hold"},    bus.rdata,   last_rdata);
    if (ok && w) begin
      check({tag, "_write_slot"},  wr_at,   WC + 1);
      check({tag, "_write_addr"},  wr_addr, a);
      check({tag, "_write_data"},  wr_data, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [31:0] a;
    rst = 1'b0;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0; bus.addr_in = '0; bus.wdata_in = '0;
    clr_mon();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_freeze",   32'(bus.freeze),      32'd0);
    check("rst_dm_read",  32'(bus.dm_read),     32'd0);
    check("rst_dm_write", 32'(bus.dm_write),    32'd0);
    check("rst_valid",    32'(bus.rdata_valid), 32'd0);
    check("rst_fault",    32'(bus.fault),       32'd0);
    check("rst_dm_addr",  bus.dm_addr,  32'h0);
    check("rst_dm_wdata", bus.dm_wdata, 32'h0);
    check("rst_rdata",    bus.rdata,    32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    run_req("store404", 1'b0, 1'b1, 32'h404, 32'hDEAD_BEEF, 1'b1);
    idle(1);
    run_req("load404",  1'b1, 1'b0, 32'h404, 32'h0, 1'b1);
    idle(1);
    run_req("store408", 1'b0, 1'b1, 32'h408, 32'h1234_5678, 1'b1);
    idle(1);
    run_req("both",     1'b1, 1'b1, 32'h404, 32'h5555_AAAA, 1'b0);
    idle(1);
    run_req("load408",  1'b1, 1'b0, 32'h408, 32'h0, 1'b1);
    idle(1);

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    run_req("load406", 1'b1, 1'b0, 32'h406, 32'h0, 1'b0);
    idle(1);
    run_req("load3fc", 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
`else
    run_req("load406", 1'b1, 1'b0, 32'h406, 32'h0, 1'b1);
    idle(1);
    run_req("load3fc", 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b1);
`endif
    idle(1);

    // back-to-back loads with the request held through DONE
    clr_mon();
    sb_q.push_back(ref_mem[1]);
    sb_q.push_back(ref_mem[1]);
    last_rdata = ref_mem[1];
    last_addr  = 32'h404;
    bus.mem_r_en = 1'b1; bus.addr_in = 32'h404;
    wait_done(seen);
    check("b2b_first_valid", 32'(bus.rdata_valid), 32'd1);
    @(negedge clk);
    check("b2b_restart_freeze", 32'(bus.freeze), 32'd1);
    wait_done(seen);
    @(posedge clk); #1;
    bus.mem_r_en = 1'b0;
    check("b2b_freeze_cycles", freeze_cnt, 2 * (WC + 1));
    check("b2b_read_cycles",   rd_cnt,     2 * WC);
    check("b2b_valids",        valid_cnt,  32'd2);
    idle(1);

    for (int i = 0; i < 8; i++) begin
      a = 32'h400 + 32'(4 * $urandom_range(0, 14));
      if ($urandom_range(0, 1) == 1)
        run_req("rnd_store", 1'b0, 1'b1, a, $urandom, 1'b1);
      else
        run_req("rnd_load", 1'b1, 1'b0, a, 32'h0, 1'b1);
      idle($urandom_range(0, 2));
    end

    // reset during the second ACCESS cycle of a store aborts it
    clr_mon();
    bus.mem_w_en = 1'b1; bus.addr_in = 32'h40C; bus.wdata_in = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    bus.mem_w_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_freeze_after", 32'(bus.freeze), 32'd0);
    idle(6);
    check("rstmid_writes",   wr_cnt,       32'd0);
    check("rstmid_valids",   valid_cnt,    32'd0);
    check("rstmid_freezes",  freeze_cnt,   32'd3);
    check("rstmid_mem",      mem[3],       ref_mem[3]);
    check("rstmid_dm_addr",  bus.dm_addr,  32'h0);
    check("rstmid_rdata",    bus.rdata,    32'h0);
    last_rdata = 32'h0;
    last_addr  = 32'h0;

    run_req("post_rst_load", 1'b1, 1'b0, 32'h408, 32'h0, 1'b1);
    idle(2);
    check("sb_leftover", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
